// File: rtl/key_conditioner_if.sv
// Pushbutton conditioner bus: raw active-low keys in, conditioned
// level/pulse outputs back. The board side (or a bench) is the master;
// the conditioner is the slave.
interface key_conditioner_if #(
  parameter int NKEYS = 3
);
  logic [NKEYS-1:0] KEY;      // raw pushbuttons, 0 = pressed, asynchronous
  logic [NKEYS-1:0] HELD;     // debounced level, 1 = pressed
  logic [NKEYS-1:0] PRESS;    // one-cycle pulse on accepted press
  logic [NKEYS-1:0] RELEASE;  // one-cycle pulse on accepted release
  logic [NKEYS-1:0] STROBE;   // press pulse or auto-repeat pulse

  modport master (
    output KEY,
    input  HELD, PRESS, RELEASE, STROBE
  );

  modport slave (
    input  KEY,
    output HELD, PRESS, RELEASE, STROBE
  );
endinterface

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key 2-FF synchroniser, counter debounce,
// registered press/release pulses and an optional auto-repeat strobe.
// Every key is an independent copy of the same pipeline.
module key_conditioner #(
  parameter int               NKEYS           = 3,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_RATE     = 5000000,
  parameter logic [NKEYS-1:0] REPEAT_EN       = 3'b011
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  key_conditioner_if.slave keys
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  // Terminal counts; every counter clears on reaching its terminal value.
  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RR_LAST = 32'(REPEAT_RATE - 1);

  logic [NKEYS-1:0] held_w;
  logic [NKEYS-1:0] press_w;
  logic [NKEYS-1:0] release_w;
  logic [NKEYS-1:0] strobe_w;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    logic        sync1_q, sync2_q;   // synchroniser, key polarity (1 = released)
    logic        stable_q, stable_d; // accepted key level, key polarity
    logic [31:0] dcnt_q, dcnt_d;     // consecutive mismatch count
    logic        press_d, release_d; // accepted edge this cycle
    logic        press_q, release_q, strobe_q;
    rpt_state_e  state_q, state_d;
    logic [31:0] rcnt_q, rcnt_d;
    logic        fire;               // repeat strobe due this cycle

    // Debounce decision: accept the synchronised level once it has
    // disagreed with the stable level for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      stable_d  = stable_q;
      dcnt_d    = dcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q == stable_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DB_LAST) begin
        stable_d  = sync2_q;
        dcnt_d    = '0;
        press_d   = ~sync2_q;
        release_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + 32'd1;
      end
    end

    // Synchroniser, debounce state and registered output pulses.
    always_ff @(posedge CLOCK_50) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value; blocking here would collapse the
      // two synchroniser stages into one.
      if (RESET) begin
        sync1_q   <= 1'b1;
        sync2_q   <= 1'b1;
        stable_q  <= 1'b1;
        dcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        strobe_q  <= 1'b0;
      end else begin
        sync1_q   <= keys.KEY[i];
        sync2_q   <= sync1_q;
        stable_q  <= stable_d;
        dcnt_q    <= dcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        strobe_q  <= press_d | fire;
      end
    end

    // Repeat FSM state register.
    always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    // Repeat FSM next state: a release in DELAY/REPEAT always wins over a
    // strobe that would fall due in the same cycle.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      case (state_q)
        ST_IDLE: begin
          if (press_d && REPEAT_EN[i]) begin
            state_d = ST_DELAY;
            rcnt_d  = '0;
          end
        end
        ST_DELAY: begin
          if (release_d) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == RD_LAST) begin
            state_d = ST_REPEAT;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 32'd1;
          end
        end
        ST_REPEAT: begin
          if (release_d) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == RR_LAST) begin
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + 32'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    // Repeat FSM output: strobe on reaching a terminal count unless released.
    always_comb begin
      fire = 1'b0;
      if (!release_d) begin
        if (state_q == ST_DELAY && rcnt_q == RD_LAST) begin
          fire = 1'b1;
        end else if (state_q == ST_REPEAT && rcnt_q == RR_LAST) begin
          fire = 1'b1;
        end
      end
    end

    assign held_w[i]    = ~stable_q;
    assign press_w[i]   = press_q;
    assign release_w[i] = release_q;
    assign strobe_w[i]  = strobe_q;
  end : g_key

  assign keys.HELD    = held_w;
  assign keys.PRESS   = press_w;
  assign keys.RELEASE = release_w;
  assign keys.STROBE  = strobe_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short timing parameters. Directed
// sequences followed by random key patterns; a reference model built on
// sliding-window debounce and press-time arithmetic feeds a scoreboard
// queue, and an independent monitor compares every DUT cycle.
module tb_key_conditioner;

  localparam int         NK   = 3;
  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RR   = 3;
  localparam logic [2:0] REN  = 3'b011;
  localparam int         MAXE = 8192;

  typedef struct packed {
    int         cyc;
    logic [2:0] held;
    logic [2:0] pr;
    logic [2:0] rl;
    logic [2:0] st;
  } ev_t;

  logic clk = 1'b1;
  logic rst;
  int   edge_n = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  key_conditioner_if #(.NKEYS(NK)) kif ();

  key_conditioner #(
    .NKEYS          (NK),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .REPEAT_EN      (REN)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .keys    (kif.slave)
  );

  // Reference model state
  logic [2:0] raw_h    [MAXE];  // KEY value present before edge e
  logic [2:0] exp_held [MAXE];  // expected HELD after edge e
  int         last_rst = 0;
  logic [2:0] m_stable = 3'b111;  // accepted level, 1 = released
  int         press_t [NK];
  ev_t        sb [$];

  task automatic check(input string name, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  // Synchronised key value seen by the debouncer before edge e.
  function automatic logic sync_at(input int e, input int i);
    if (e <= last_rst + 2) return 1'b1;
    return raw_h[e-2][i];
  endfunction

  // Expected behaviour at edge t, from the debounce window rule and the
  // repeat schedule measured from the accepted press edge.
  task automatic model_step(input int t, input logic r);
    logic [2:0] pr, rl, st;
    logic       acc;
    int         d;
    ev_t        ev;
    pr = '0; rl = '0; st = '0;
    if (r) begin
      last_rst = t;
      m_stable = 3'b111;
    end else begin
      for (int i = 0; i < NK; i++) begin
        acc = (t - DB + 1 > last_rst);
        for (int k = 0; k < DB; k++)
          if (sync_at(t - k, i) == m_stable[i]) acc = 1'b0;
        if (acc) begin
          m_stable[i] = ~m_stable[i];
          if (m_stable[i] == 1'b0) begin
            pr[i] = 1'b1;
            st[i] = 1'b1;
            press_t[i] = t;
          end else begin
            rl[i] = 1'b1;
          end
        end else if (m_stable[i] == 1'b0 && REN[i]) begin
          d = t - press_t[i];
          if (d == RD || (d > RD && (d - RD) % RR == 0)) st[i] = 1'b1;
        end
      end
    end
    exp_held[t] = ~m_stable;
    if ((pr | rl | st) != 3'b000) begin
      ev.cyc = t; ev.held = ~m_stable; ev.pr = pr; ev.rl = rl; ev.st = st;
      sb.push_back(ev);
    end
  endtask

  // Drive one cycle of stimulus and record the matching expectation.
  task automatic cycle(input logic [2:0] k, input logic r);
    int t;
    @(negedge clk);
    kif.KEY = k;
    rst     = r;
    t = edge_n + 1;
    if (t >= MAXE) begin
      $display("FAIL stimulus_overrun @edge %0d: got %0d expected below %0d", t, t, MAXE);
      $fatal(1, "stimulus exceeded history depth");
    end
    raw_h[t] = k;
    model_step(t, r);
  endtask

  task automatic hold(input logic [2:0] k, input int n);
    for (int j = 0; j < n; j++) cycle(k, 1'b0);
  endtask

  // Monitor: compare HELD every cycle, pop the scoreboard on any pulse.
  initial begin
    int  c;
    ev_t e;
    logic [2:0] pr, rl, st;
    forever begin
      @(posedge clk);
      #1;
      c  = edge_n;
      pr = kif.PRESS; rl = kif.RELEASE; st = kif.STROBE;
      check("held", c, 32'(kif.HELD), 32'(exp_held[c]));
      if ((pr | rl | st) != 3'b000) begin
        if (sb.size() == 0 || sb[0].cyc != c) begin
          check("unexpected_pulse", c, 32'({pr, rl, st}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("press",   c, 32'(pr), 32'(e.pr));
          check("release", c, 32'(rl), 32'(e.rl));
          check("strobe",  c, 32'(st), 32'(e.st));
        end
      end else if (sb.size() != 0 && sb[0].cyc <= c) begin
        e = sb.pop_front();
        check("missing_pulse", c, 32'({pr, rl, st}), 32'({e.pr, e.rl, e.st}));
      end
    end
  end

  // Stimulus
  initial begin
    int         len;
    logic [2:0] kv;
    kif.KEY = 3'b111;
    rst     = 1'b1;
    for (int j = 0; j < 3; j++) cycle(3'b111, 1'b1);
    hold(3'b111, 5);

    // Clean press and release of key 0
    hold(3'b110, 5);
    hold(3'b111, 12);

    // Bouncing key 1 then settled press and release
    cycle(3'b101, 1'b0); cycle(3'b111, 1'b0);
    cycle(3'b101, 1'b0); cycle(3'b111, 1'b0);
    hold(3'b101, 12);
    hold(3'b111, 12);

    // Long hold of key 0 with auto-repeat, released during REPEAT
    hold(3'b110, 40);
    hold(3'b111, 12);

    // Key 2 has no auto-repeat; then a short glitch that must be ignored
    hold(3'b011, 40);
    hold(3'b111, 10);
    hold(3'b011, 3);
    hold(3'b111, 10);

    // Keys 0 and 1 together
    hold(3'b100, 25);
    hold(3'b111, 12);

    // Reset while key 0 is repeating; key stays held through reset
    hold(3'b110, 25);
    cycle(3'b110, 1'b1); cycle(3'b110, 1'b1);
    hold(3'b110, 25);
    hold(3'b111, 12);

    // Random patterns with occasional resets
    for (int s = 0; s < 120; s++) begin
      len = int'($urandom_range(1, 20));
      kv  = 3'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        cycle(kv, 1'b1);
        cycle(kv, 1'b1);
      end
      hold(kv, len);
    end

    // Drain with all keys released
    hold(3'b111, 20);
    @(posedge clk);
    #2;
    check("scoreboard_empty", edge_n, 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
